// File: rtl/adc_seqctrl.sv
// rtl/adc_seqctrl.sv - SAR ADC conversion sequencer with strobe generation and result buffer
module adc_seqctrl #(
   parameter int MAX_BITS    = 16,
   parameter int COMP_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst_b,
   input  logic                start,
   input  logic                abort,
   input  logic [4:0]          cfg_nbits,
   input  logic [7:0]          cfg_samp_cycles,
   input  logic                cfg_continuous,
   input  logic                comp_out,
   output logic                seq_init,
   output logic                seq_samp,
   output logic                seq_comp,
   output logic                seq_update,
   output logic                busy,
   output logic [MAX_BITS-1:0] result,
   output logic                result_valid,
   input  logic                result_ready,
   output logic                overrun,
   input  logic                overrun_clr
);

   localparam int BW = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_SAMP, S_COMP, S_UPDATE, S_DONE
   } state_t;

   state_t              state, next_state;
   logic [7:0]          cnt;
   logic [7:0]          samp_len;
   logic [BW-1:0]       bit_cnt;
   logic [BW-1:0]       nlast;
   logic                cont;
   logic [MAX_BITS-1:0] sreg;
   logic [4:0]          nbits_eff;
   logic                accept, samp_end, comp_end, last_bit, load, drop;
   logic                seq_init_d, seq_samp_d, seq_comp_d, seq_update_d, busy_d;

   assign nbits_eff = (cfg_nbits == 5'd0)            ? 5'd1 :
                      (cfg_nbits > 5'(MAX_BITS))     ? 5'(MAX_BITS) : cfg_nbits;
   assign accept    = (state == S_IDLE) && start && !abort;
   assign samp_end  = (cnt == samp_len - 8'd1);
   assign comp_end  = (cnt == 8'(COMP_CYCLES - 1));
   assign last_bit  = (bit_cnt == nlast);
   // Abort in DONE discards the conversion, so neither the buffer nor overrun moves.
   assign load      = (state == S_DONE) && !abort && (!result_valid || result_ready);
   assign drop      = (state == S_DONE) && !abort && result_valid && !result_ready;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) state <= S_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (abort) begin
         next_state = S_IDLE;
      end else begin
         case (state)
            S_IDLE:   if (start) next_state = S_INIT;
            S_INIT:   next_state = S_SAMP;
            S_SAMP:   if (samp_end) next_state = S_COMP;
            S_COMP:   if (comp_end) next_state = S_UPDATE;
            S_UPDATE: next_state = last_bit ? S_DONE : S_COMP;
            S_DONE:   next_state = cont ? S_INIT : S_IDLE;
            default:  next_state = S_IDLE;
         endcase
      end
   end

   // Strobes are decoded from the next state and registered, so they are glitch-free flops.
   always_comb begin
      seq_init_d   = (next_state == S_INIT);
      seq_samp_d   = (next_state == S_SAMP);
      seq_comp_d   = (next_state == S_COMP);
      seq_update_d = (next_state == S_UPDATE);
      busy_d       = (next_state != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         seq_init     <= 1'b0;
         seq_samp     <= 1'b0;
         seq_comp     <= 1'b0;
         seq_update   <= 1'b0;
         busy         <= 1'b0;
         cnt          <= 8'd0;
         bit_cnt      <= '0;
         sreg         <= '0;
         nlast        <= '0;
         samp_len     <= 8'd0;
         cont         <= 1'b0;
         result       <= '0;
         result_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         seq_init   <= seq_init_d;
         seq_samp   <= seq_samp_d;
         seq_comp   <= seq_comp_d;
         seq_update <= seq_update_d;
         busy       <= busy_d;

         if ((next_state != state) || (state == S_IDLE)) cnt <= 8'd0;
         else                                            cnt <= cnt + 8'd1;

         if (abort || state == S_INIT)             bit_cnt <= '0;
         else if (state == S_UPDATE && !last_bit)  bit_cnt <= bit_cnt + 1'b1;

         if (state == S_INIT)
            sreg <= '0;
         else if (state == S_COMP && comp_end && !abort)
            sreg <= {sreg[MAX_BITS-2:0], comp_out};

         if (accept) begin
            nlast    <= BW'(nbits_eff - 5'd1);
            samp_len <= (cfg_samp_cycles == 8'd0) ? 8'd1 : cfg_samp_cycles;
            cont     <= cfg_continuous;
         end

         // INIT clears sreg and only N bits are shifted in, so the upper bits are already zero.
         if (load) begin
            result       <= sreg;
            result_valid <= 1'b1;
         end else if (result_valid && result_ready) begin
            result_valid <= 1'b0;
         end

         if (drop)             overrun <= 1'b1;
         else if (overrun_clr) overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_adc_seqctrl.sv
// tb/tb_adc_seqctrl.sv - directed bench for adc_seqctrl
module tb_adc_seqctrl;

   logic        clk = 1'b0;
   logic        rst_b, start, abort, cfg_continuous, comp_out;
   logic [4:0]  cfg_nbits;
   logic [7:0]  cfg_samp_cycles;
   logic        seq_init, seq_samp, seq_comp, seq_update, busy;
   logic [15:0] result;
   logic        result_valid, result_ready, overrun, overrun_clr;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc      = 0;
   int          n_init, n_samp, n_comp, n_upd, onehot_bad;
   int          tb_n     = 16;
   logic [15:0] tb_vin   = 16'h0;
   int          idx      = 0;
   int          lat, v1, groups;
   logic        prev_comp;

   adc_seqctrl #(.MAX_BITS(16), .COMP_CYCLES(2)) dut (
      .clk(clk), .rst_b(rst_b), .start(start), .abort(abort),
      .cfg_nbits(cfg_nbits), .cfg_samp_cycles(cfg_samp_cycles),
      .cfg_continuous(cfg_continuous), .comp_out(comp_out),
      .seq_init(seq_init), .seq_samp(seq_samp), .seq_comp(seq_comp),
      .seq_update(seq_update), .busy(busy), .result(result),
      .result_valid(result_valid), .result_ready(result_ready),
      .overrun(overrun), .overrun_clr(overrun_clr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Comparator model: presents vin MSB first, advancing one bit per update strobe.
   initial comp_out = 1'b0;
   always @(posedge clk) begin
      #2;
      if (seq_init)                idx = tb_n - 1;
      else if (seq_update && idx > 0) idx = idx - 1;
      comp_out = tb_vin[idx];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample_strobes();
      n_init += int'(seq_init);
      n_samp += int'(seq_samp);
      n_comp += int'(seq_comp);
      n_upd  += int'(seq_update);
      if (int'(seq_init) + int'(seq_samp) + int'(seq_comp) + int'(seq_update) > 1) onehot_bad++;
   endtask

   // Latency counts edges with the start-accepting edge as edge 1.
   task automatic run_conv(input int poke_at, output int latency);
      int edges;
      n_init = 0; n_samp = 0; n_comp = 0; n_upd = 0; onehot_bad = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      edges = 1;
      sample_strobes();
      while (!result_valid && edges < 200) begin
         if (edges == poke_at) begin
            start     = 1'b1;
            cfg_nbits = 5'd16;
         end else begin
            start = 1'b0;
         end
         tick();
         edges++;
         sample_strobes();
      end
      start   = 1'b0;
      latency = result_valid ? edges : -1;
   endtask

   task automatic pop();
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
   endtask

   task automatic wait_cyc(input int target);
      int guard;
      guard = 0;
      while (cyc < target && guard < 1000) begin
         tick();
         guard++;
      end
   endtask

   initial begin
      rst_b = 1'b0; start = 1'b0; abort = 1'b0; cfg_continuous = 1'b0;
      cfg_nbits = 5'd16; cfg_samp_cycles = 8'd4;
      result_ready = 1'b0; overrun_clr = 1'b0;
      repeat (3) tick();
      check("reset_flags", {seq_init, seq_samp, seq_comp, seq_update, busy, result_valid, overrun}, 0);
      check("reset_result", result, 0);
      @(negedge clk) rst_b = 1'b1;
      tick();

      // Default 16-bit conversion
      tb_n = 16; tb_vin = 16'hA5C3;
      run_conv(0, lat);
      check("def_latency", lat, 55);
      check("def_result", result, 16'hA5C3);
      check("def_n_init", n_init, 1);
      check("def_n_samp", n_samp, 4);
      check("def_n_comp", n_comp, 32);
      check("def_n_upd", n_upd, 16);
      check("def_onehot", onehot_bad, 0);
      check("def_busy_done", busy, 0);
      pop();
      check("def_popped", result_valid, 0);

      // Short conversion with zero sample cycles
      cfg_nbits = 5'd4; cfg_samp_cycles = 8'd0;
      tb_n = 4; tb_vin = 16'h000B;
      run_conv(0, lat);
      check("n4_latency", lat, 16);
      check("n4_result", result, 16'h000B);
      check("n4_n_samp", n_samp, 1);
      check("n4_n_upd", n_upd, 4);
      pop();

      // nbits=0 behaves as one bit
      cfg_nbits = 5'd0; cfg_samp_cycles = 8'd1;
      tb_n = 1; tb_vin = 16'h0001;
      run_conv(0, lat);
      check("n0_latency", lat, 7);
      check("n0_result", result, 16'h0001);
      pop();

      // nbits above MAX_BITS clamps to 16
      cfg_nbits = 5'd31; cfg_samp_cycles = 8'd1;
      tb_n = 16; tb_vin = 16'h1234;
      run_conv(0, lat);
      check("n31_latency", lat, 52);
      check("n31_result", result, 16'h1234);
      pop();

      // Continuous mode with a stalled consumer
      cfg_nbits = 5'd4; cfg_samp_cycles = 8'd2; cfg_continuous = 1'b1;
      tb_n = 4; tb_vin = 16'h0009;
      run_conv(0, lat);
      check("cont_latency", lat, 17);
      check("cont_result1", result, 16'h0009);
      v1 = cyc;
      tb_vin = 16'h0006;
      wait_cyc(v1 + 15);
      check("cont_no_ovr_yet", overrun, 0);
      wait_cyc(v1 + 16);
      check("cont_overrun", overrun, 1);
      check("cont_result_held", result, 16'h0009);
      check("cont_valid_held", result_valid, 1);
      overrun_clr = 1'b1;
      tb_vin = 16'h0005;
      tick();
      overrun_clr = 1'b0;
      check("cont_ovr_cleared", overrun, 0);
      wait_cyc(v1 + 31);
      check("cont_done_strobes", {seq_init, seq_samp, seq_comp, seq_update, busy}, 5'b00001);
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      check("cont_reload_valid", result_valid, 1);
      check("cont_reload_result", result, 16'h0005);
      check("cont_reload_no_ovr", overrun, 0);
      wait_cyc(v1 + 47);
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      check("cont_clr_vs_set", overrun, 1);
      check("cont_result_kept", result, 16'h0005);
      cfg_continuous = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("cont_abort_idle", busy, 0);

      // Abort during the third comparator phase
      cfg_nbits = 5'd8; cfg_samp_cycles = 8'd1;
      tb_n = 8; tb_vin = 16'h00FF;
      start = 1'b1;
      tick();
      start = 1'b0;
      groups = 0; prev_comp = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (seq_comp && !prev_comp) groups++;
         if (groups == 3) break;
         prev_comp = seq_comp;
         tick();
      end
      check("abort_found_comp3", groups, 3);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_outputs", {seq_init, seq_samp, seq_comp, seq_update, busy}, 0);
      check("abort_result", result, 16'h0005);
      check("abort_flags", {result_valid, overrun}, 2'b11);
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      check("start_abort_idle1", {busy, seq_init}, 0);
      tick();
      check("start_abort_idle2", {busy, seq_init}, 0);

      // Start while busy and config change mid-conversion are ignored
      pop();
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      check("pre_t5_flags", {result_valid, overrun}, 0);
      cfg_nbits = 5'd4; cfg_samp_cycles = 8'd1;
      tb_n = 4; tb_vin = 16'h000C;
      run_conv(5, lat);
      check("latch_latency", lat, 16);
      check("latch_result", result, 16'h000C);
      check("latch_n_upd", n_upd, 4);
      repeat (3) tick();
      check("latch_no_restart", busy, 0);
      pop();

      // Asynchronous reset mid-sample
      cfg_nbits = 5'd16; cfg_samp_cycles = 8'd4;
      tb_n = 16; tb_vin = 16'hA5C3;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("pre_reset_samp", seq_samp, 1);
      #2 rst_b = 1'b0;
      #1;
      check("async_reset_flags", {seq_init, seq_samp, seq_comp, seq_update, busy, result_valid, overrun}, 0);
      check("async_reset_result", result, 0);
      @(negedge clk) rst_b = 1'b1;
      tick();
      run_conv(0, lat);
      check("post_reset_latency", lat, 55);
      check("post_reset_result", result, 16'hA5C3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/adc_seqctrl.md
Name: adc_seqctrl

Overview:
- Synchronous conversion sequencer for the SAR ADC macro.
- Generates the four sequencing strobes (seq_init, seq_samp, seq_comp, seq_update) that the ADC's clock gate turns into its gated clocks.
- Captures the comparator decision (comp_out) once per bit and assembles an MSB-first result word.
- Presents the result through a valid/ready output buffer, with single-shot or continuous conversion modes and an abort.

Parameters:
- MAX_BITS, 16, width of result bus and upper limit of cfg_nbits; matches the 16-bit DAC state buses.
- COMP_CYCLES, 2, clock cycles seq_comp stays high per bit; legal range is 2..15.

Ports:
- clk  in  1  sequencer clock; single clock domain.
- rst_b  in  1  asynchronous active-low reset.
- start  in  1  conversion request; sampled only in IDLE.
- abort  in  1  synchronous abort; highest priority after reset.
- cfg_nbits  in  5  bits per conversion; 0 is treated as 1, values >MAX_BITS are treated as MAX_BITS.
- cfg_samp_cycles  in  8  seq_samp high time in cycles; 0 is treated as 1.
- cfg_continuous  in  1  when 1, restart automatically after each conversion.
- comp_out  in  1  comparator decision from the ADC.
- seq_init  out  1  initialization strobe.
- seq_samp  out  1  sampling strobe.
- seq_comp  out  1  comparator strobe.
- seq_update  out  1  SAR logic update strobe.
- busy  out  1  high in any state other than IDLE.
- result  out  MAX_BITS  conversion result, right-aligned, upper bits zero.
- result_valid  out  1  result buffer is full.
- result_ready  in  1  consumer accepts the result.
- overrun  out  1  sticky: a completed result was dropped.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Reset (rst_b low, asynchronous): state IDLE; all seq_* outputs 0; busy 0; result 0; result_valid 0; overrun 0; all counters 0.
- Registered outputs: every seq_* output and busy is a flop output, never decoded combinationally. At most one seq_* output is high in any cycle.
- Config latching: cfg_nbits, cfg_samp_cycles and cfg_continuous are latched on the edge that accepts start. Config changes mid-conversion have no effect.

State machine (one state per cycle unless a count is given):
- IDLE: if start=1, go to INIT. start is ignored in every other state.
- INIT: 1 cycle, seq_init=1. Clears the shift register and the bit counter. Next state SAMP.
- SAMP: S cycles, seq_samp=1, where S is the effective cfg_samp_cycles. Next state COMP.
- COMP: COMP_CYCLES cycles, seq_comp=1. comp_out is captured on the edge that ends the last COMP cycle: shift register becomes {sreg[MAX_BITS-2:0], comp_out}. Next state UPDATE.
- UPDATE: 1 cycle, seq_update=1. If the bit counter equals N-1 (N = effective nbits), go to DONE; otherwise increment the counter and go to COMP.
- DONE: 1 cycle, all seq_* outputs 0.
  - If result_valid=0, or result_valid=1 and result_ready=1 in this cycle: load result from the shift register (low N bits, upper bits zero) and set result_valid.
  - Otherwise drop the new result and set overrun.
  - Next state INIT if the latched cfg_continuous=1, else IDLE.

Output buffer and flags:
- Handshake: result_valid falls on the edge where result_valid=1 and result_ready=1, unless DONE reloads the buffer on that same edge. result holds its value while result_valid=1.
- Overrun: stays set until overrun_clr=1 or reset. If overrun_clr and a new overrun occur in the same cycle, overrun stays 1.

Abort:
- abort=1 in any state forces IDLE on the next edge; all seq_* outputs go 0 on that edge.
- The partial conversion is discarded. The result buffer and overrun flag are unchanged.
- abort and start in the same cycle: abort wins and the sequencer stays IDLE.

Timing:
- Latency: result_valid is high 3 + S + N*(COMP_CYCLES+1) cycles after the edge that accepts start.
- Example: N=16, S=4, C=2 gives 55 cycles.
- Continuous mode: period is 2 + S + N*(C+1) cycles per conversion.

Test Plan:
- Default config (N=16, S=4, C=2); comp_out driven by a model of vin=0xA5C3, MSB first -> seq_init 1 cycle, seq_samp 4 cycles, then 16 alternating comp/update groups of 2+1 cycles; result=0xA5C3 with result_valid high exactly 55 cycles after start.
- cfg_nbits=4, cfg_samp_cycles=0, comp_out bits 1,0,1,1 -> seq_samp high 1 cycle; result=0x000B; valid 3+1+12=16 cycles after start; cfg_nbits=0 yields a 1-bit conversion.
- Continuous mode with result_ready held 0, N=4, S=2 -> first result buffered; second DONE sets overrun and leaves result unchanged; overrun_clr pulse clears overrun; result_ready=1 in a DONE cycle loads the new result with no overrun.
- abort asserted during the 3rd COMP -> all seq_* outputs 0 next cycle, busy 0, previous result and result_valid untouched; start and abort asserted together -> stays IDLE.
- start pulsed while busy, plus cfg_nbits changed mid-conversion -> no restart; bit count follows the latched value.
- rst_b asserted asynchronously mid-SAMP -> all outputs 0 immediately, without waiting for a clock edge; first start after reset release gives normal 55-cycle latency.
